// File: rtl/bnw_game_pkg.sv
// Shared types and constants for the piano rhythm game controller.
package bnw_game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } game_state_e;

  localparam int BEAT_W = 7;
  localparam int NOTE_W = 6;

  localparam int DEF_LAST_BEAT      = 96;
  localparam int DEF_TICKS_PER_BEAT = 25_000_000;
  localparam int DEF_TICK_W         = 25;

  // Saturation limits for the scoring counters.
  localparam int SCORE_MAX = 63;
  localparam int MISS_MAX  = 127;

endpackage

// File: rtl/beat_timer.sv
// Tick divider and beat counter. load restarts the song at beat 1;
// run advances the tick, and the beat advances on each tick wrap until
// the final beat, where it holds.
module beat_timer
  import bnw_game_pkg::*;
#(
  parameter int TICKS_PER_BEAT = DEF_TICKS_PER_BEAT,
  parameter int TICK_W         = DEF_TICK_W,
  parameter int LAST_BEAT      = DEF_LAST_BEAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              load,
  output logic [BEAT_W-1:0] beat_cnt,
  output logic              beat_wrap,
  output logic              last
);

  logic [TICK_W-1:0] tick;

  assign beat_wrap = run && (tick == TICK_W'(TICKS_PER_BEAT - 1));
  assign last      = (beat_cnt == BEAT_W'(LAST_BEAT));

  // Tick divider and beat counter; load wins over run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick     <= '0;
      beat_cnt <= '0;
    end else if (load) begin
      tick     <= '0;
      beat_cnt <= BEAT_W'(1);
    end else if (run) begin
      if (beat_wrap) begin
        tick <= '0;
        if (!last) beat_cnt <= beat_cnt + BEAT_W'(1);
      end else begin
        tick <= tick + TICK_W'(1);
      end
    end
  end

endmodule

// File: rtl/beat_judge_ctrl.sv
// Game-play controller: sequences the song beats, detects new notes from
// the lookup's note index and judges key presses into score/combo/miss.
// All judging happens only in PLAY with pause low; PAUSE freezes everything.
module beat_judge_ctrl
  import bnw_game_pkg::*;
#(
  parameter int TICKS_PER_BEAT = DEF_TICKS_PER_BEAT,
  parameter int TICK_W         = DEF_TICK_W,
  parameter int LAST_BEAT      = DEF_LAST_BEAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pause,
  input  logic              key_hit,
  input  logic [NOTE_W-1:0] note_idx,
  output logic [BEAT_W-1:0] beat_cnt,
  output logic [5:0]        score,
  output logic [5:0]        combo,
  output logic [5:0]        max_combo,
  output logic [6:0]        miss_cnt,
  output logic              judge_hit,
  output logic              judge_miss,
  output logic              busy,
  output logic              done
);

  game_state_e       state, state_next;
  logic              run, load, beat_wrap, last, song_end, new_note;
  logic              pending;
  logic [NOTE_W-1:0] prev_idx;
  logic              hit, bad_press, expire, miss;
  logic [5:0]        combo_inc;

  assign run      = (state == PLAY) && !pause;
  assign load     = start && ((state == IDLE) || (state == DONE));
  assign song_end = beat_wrap && last;
  assign new_note = run && (note_idx != '0) && (note_idx != prev_idx);
  assign busy     = (state == PLAY) || (state == PAUSE);
  assign done     = (state == DONE);

  beat_timer #(
    .TICKS_PER_BEAT(TICKS_PER_BEAT),
    .TICK_W        (TICK_W),
    .LAST_BEAT     (LAST_BEAT)
  ) u_beat_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .load     (load),
    .beat_cnt (beat_cnt),
    .beat_wrap(beat_wrap),
    .last     (last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; pause outranks the end-of-song transition.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = PLAY;
      PLAY: begin
        if (pause)         state_next = PAUSE;
        else if (song_end) state_next = DONE;
      end
      PAUSE: if (!pause) state_next = PLAY;
      default: state_next = IDLE;
    endcase
  end

  // Judge decode: a hit credits the pending note before any expiry check,
  // so a hit and a new note in one cycle never count as a miss.
  always_comb begin
    hit       = run && key_hit && pending;
    bad_press = run && key_hit && !pending;
    expire    = pending && !hit && (new_note || song_end);
    miss      = bad_press || expire;
    combo_inc = (combo == 6'(SCORE_MAX)) ? combo : combo + 6'd1;
  end

  // Scoring registers and judge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score      <= '0;
      combo      <= '0;
      max_combo  <= '0;
      miss_cnt   <= '0;
      judge_hit  <= 1'b0;
      judge_miss <= 1'b0;
      pending    <= 1'b0;
      prev_idx   <= '0;
    end else begin
      judge_hit  <= 1'b0;
      judge_miss <= 1'b0;
      if (load) begin
        score     <= '0;
        combo     <= '0;
        max_combo <= '0;
        miss_cnt  <= '0;
        pending   <= 1'b0;
        prev_idx  <= '0;
      end else begin
        if (hit) begin
          score     <= (score == 6'(SCORE_MAX)) ? score : score + 6'd1;
          combo     <= combo_inc;
          if (combo_inc > max_combo) max_combo <= combo_inc;
          pending   <= 1'b0;
          judge_hit <= 1'b1;
        end
        if (miss) begin
          miss_cnt   <= (miss_cnt == 7'(MISS_MAX)) ? miss_cnt : miss_cnt + 7'd1;
          combo      <= '0;
          judge_miss <= 1'b1;
        end
        if (new_note) begin
          pending  <= 1'b1;
          prev_idx <= note_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_beat_judge_ctrl.sv
// Bench for beat_judge_ctrl with a short beat period and a 47-note song model.
module tb_beat_judge_ctrl;

  localparam int TPB  = 4;
  localparam int LAST = 96;

  localparam int M_IDLE  = 0;
  localparam int M_PLAY  = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic       clk, rst_n, start, pause, key_hit;
  logic [5:0] note_idx;
  logic [6:0] beat_cnt;
  logic [5:0] score, combo, max_combo;
  logic [6:0] miss_cnt;
  logic       judge_hit, judge_miss, busy, done;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int m_phase, m_beat, m_tick, m_score, m_combo, m_maxc, m_miss, m_prev;
  bit m_pending, m_hit, m_missp, m_event;

  typedef struct {
    bit key;
    int beat;
    int score;
    int combo;
    int maxc;
    int miss;
    bit hit;
    bit missp;
  } vec_t;
  vec_t vecs[15];

  beat_judge_ctrl #(
    .TICKS_PER_BEAT(TPB),
    .TICK_W        (2),
    .LAST_BEAT     (LAST)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pause     (pause),
    .key_hit   (key_hit),
    .note_idx  (note_idx),
    .beat_cnt  (beat_cnt),
    .score     (score),
    .combo     (combo),
    .max_combo (max_combo),
    .miss_cnt  (miss_cnt),
    .judge_hit (judge_hit),
    .judge_miss(judge_miss),
    .busy      (busy),
    .done      (done)
  );

  // Song lookup: notes 1..24 on beats 1..24, then notes 25..47 every third beat from 25.
  function automatic logic [5:0] song_note(input int b);
    if (b >= 1 && b <= 24) return 6'(b);
    if (b >= 25 && b <= 91 && ((b - 25) % 3) == 0) return 6'(25 + (b - 25) / 3);
    return 6'd0;
  endfunction

  assign note_idx = song_note(int'(beat_cnt));

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = M_IDLE; m_beat = 0; m_tick = 0; m_score = 0; m_combo = 0;
    m_maxc = 0; m_miss = 0; m_prev = 0; m_pending = 0;
    m_hit = 0; m_missp = 0; m_event = 0;
  endtask

  // One clock of the game rules, evaluated on the pre-edge state.
  task automatic model_step(input bit st, input bit ps, input bit k);
    int nidx;
    bit ev, song_end, was_pending, credited, missed;
    nidx = int'(song_note(m_beat));
    m_hit = 0; m_missp = 0; m_event = 0;
    if (m_phase == M_IDLE || m_phase == M_DONE) begin
      if (st) begin
        m_phase = M_PLAY; m_beat = 1; m_tick = 0; m_score = 0; m_combo = 0;
        m_maxc = 0; m_miss = 0; m_pending = 0; m_prev = 0;
      end
    end else if (m_phase == M_PAUSE) begin
      if (!ps) m_phase = M_PLAY;
    end else if (ps) begin
      m_phase = M_PAUSE;
    end else begin
      ev          = (nidx != 0) && (nidx != m_prev);
      song_end    = (m_tick == TPB - 1) && (m_beat == LAST);
      was_pending = m_pending;
      credited    = 0;
      missed      = 0;
      if (k && was_pending) begin
        credited  = 1;
        m_score   = (m_score < 63) ? m_score + 1 : 63;
        m_combo   = (m_combo < 63) ? m_combo + 1 : 63;
        if (m_combo > m_maxc) m_maxc = m_combo;
        m_pending = 0;
        m_hit     = 1;
      end else if (k) begin
        missed = 1;
      end
      if ((ev || song_end) && was_pending && !credited) missed = 1;
      if (missed) begin
        m_miss  = (m_miss < 127) ? m_miss + 1 : 127;
        m_combo = 0;
        m_missp = 1;
      end
      if (ev) begin
        m_pending = 1;
        m_prev    = nidx;
      end
      m_event = ev;
      if (m_tick == TPB - 1) begin
        m_tick = 0;
        if (m_beat == LAST) m_phase = M_DONE;
        else m_beat++;
      end else begin
        m_tick++;
      end
    end
  endtask

  task automatic compare_model();
    check("beat_cnt", int'(beat_cnt), m_beat);
    check("score", int'(score), m_score);
    check("combo", int'(combo), m_combo);
    check("max_combo", int'(max_combo), m_maxc);
    check("miss_cnt", int'(miss_cnt), m_miss);
    check("judge_hit", int'(judge_hit), int'(m_hit));
    check("judge_miss", int'(judge_miss), int'(m_missp));
    check("busy", int'(busy), int'(m_phase == M_PLAY || m_phase == M_PAUSE));
    check("done", int'(done), int'(m_phase == M_DONE));
  endtask

  // Drive one cycle of inputs, clock it, then compare against the model.
  task automatic step(input bit st, input bit ps, input bit k);
    start = st; pause = ps; key_hit = k;
    model_step(st, ps, k);
    @(posedge clk);
    #1;
    start = 0; pause = 0; key_hit = 0;
    compare_model();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_beat"}, int'(beat_cnt), 0);
    check({tag, "_score"}, int'(score), 0);
    check({tag, "_combo"}, int'(combo), 0);
    check({tag, "_maxc"}, int'(max_combo), 0);
    check({tag, "_miss"}, int'(miss_cnt), 0);
    check({tag, "_jhit"}, int'(judge_hit), 0);
    check({tag, "_jmiss"}, int'(judge_miss), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 0;
    #3;
    check_all_zero(tag);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    int guard, play_cycles, miss_pulses;
    bit key;

    rst_n = 0; start = 0; pause = 0; key_hit = 0;
    model_reset();

    vecs[0]  = '{0, 1, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 1, 1, 1, 1, 0, 1, 0};
    vecs[2]  = '{0, 1, 1, 1, 1, 0, 0, 0};
    vecs[3]  = '{0, 2, 1, 1, 1, 0, 0, 0};
    vecs[4]  = '{0, 2, 1, 1, 1, 0, 0, 0};
    vecs[5]  = '{1, 2, 2, 2, 2, 0, 1, 0};
    vecs[6]  = '{1, 2, 2, 0, 2, 1, 0, 1};
    vecs[7]  = '{0, 3, 2, 0, 2, 1, 0, 0};
    vecs[8]  = '{0, 3, 2, 0, 2, 1, 0, 0};
    vecs[9]  = '{0, 3, 2, 0, 2, 1, 0, 0};
    vecs[10] = '{0, 3, 2, 0, 2, 1, 0, 0};
    vecs[11] = '{0, 4, 2, 0, 2, 1, 0, 0};
    vecs[12] = '{1, 4, 3, 1, 2, 1, 1, 0};
    vecs[13] = '{1, 4, 4, 2, 2, 1, 1, 0};
    vecs[14] = '{0, 4, 4, 2, 2, 1, 0, 0};

    // Reset state, then directed opening of a song: hits, bad press,
    // and a hit coinciding with the next note's arrival.
    do_reset("rst0");
    step(1, 0, 0);
    check("start_beat", int'(beat_cnt), 1);
    check("start_busy", int'(busy), 1);
    for (int i = 0; i < 15; i++) begin
      step(0, 0, vecs[i].key);
      check($sformatf("v%0d_beat", i), int'(beat_cnt), vecs[i].beat);
      check($sformatf("v%0d_score", i), int'(score), vecs[i].score);
      check($sformatf("v%0d_combo", i), int'(combo), vecs[i].combo);
      check($sformatf("v%0d_maxc", i), int'(max_combo), vecs[i].maxc);
      check($sformatf("v%0d_miss", i), int'(miss_cnt), vecs[i].miss);
      check($sformatf("v%0d_jhit", i), int'(judge_hit), int'(vecs[i].hit));
      check($sformatf("v%0d_jmiss", i), int'(judge_miss), int'(vecs[i].missp));
    end

    // Pause for 10 cycles during beat 5 with keys pressed: nothing moves.
    step(0, 0, 0);
    step(0, 0, 0);
    check("pre_pause_beat", int'(beat_cnt), 5);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 1);
      check("pause_beat", int'(beat_cnt), 5);
      check("pause_jhit", int'(judge_hit), 0);
      check("pause_jmiss", int'(judge_miss), 0);
      check("pause_busy", int'(busy), 1);
      check("pause_score", int'(score), 4);
    end
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    check("resume_beat_a", int'(beat_cnt), 5);
    step(0, 0, 0);
    check("resume_beat_b", int'(beat_cnt), 6);

    // Full song, key one cycle after each new note.
    do_reset("rst1");
    step(1, 0, 0);
    play_cycles = 0; key = 0; guard = 0;
    while (!done && guard < 600) begin
      if (m_phase == M_PLAY) play_cycles++;
      step(0, 0, key);
      key = m_event;
      guard++;
    end
    check("full_done", int'(done), 1);
    check("full_play_cycles", play_cycles, 384);
    check("full_score", int'(score), 47);
    check("full_combo", int'(combo), 47);
    check("full_maxc", int'(max_combo), 47);
    check("full_miss", int'(miss_cnt), 0);
    check("full_beat", int'(beat_cnt), 96);

    // Full song with no presses: every note expires.
    step(1, 0, 0);
    miss_pulses = 0; guard = 0;
    while (!done && guard < 600) begin
      step(0, 0, 0);
      miss_pulses += int'(judge_miss);
      guard++;
    end
    check("idle_done", int'(done), 1);
    check("idle_miss_pulses", miss_pulses, 47);
    check("idle_miss_cnt", int'(miss_cnt), 47);
    check("idle_score", int'(score), 0);
    check("idle_combo", int'(combo), 0);

    // Reset mid-song at beat 40, then restart.
    step(1, 0, 0);
    guard = 0;
    while (beat_cnt != 7'd40 && guard < 400) begin
      step(0, 0, $urandom_range(0, 3) == 0);
      guard++;
    end
    check("reach_beat40", int'(beat_cnt), 40);
    do_reset("rst_mid");
    step(1, 0, 0);
    check("restart_beat", int'(beat_cnt), 1);
    check("restart_score", int'(score), 0);
    check("restart_miss", int'(miss_cnt), 0);

    // Randomized play with occasional start/pause, checked against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) < 20);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
